// File: rtl/ifetch_stage_pkg.sv
// Shared widths, FSM encoding and helpers for the instruction fetch stage.
package ifetch_stage_pkg;

  localparam int ADDR_W_DEF     = 8;
  localparam int INSTR_W_DEF    = 16;
  localparam int FIFO_DEPTH_DEF = 2;

  typedef enum logic [1:0] {
    FS_IDLE    = 2'd0,
    FS_REQ     = 2'd1,
    FS_DISCARD = 2'd2
  } fs_state_e;

  // Occupancy counter needs one extra bit so that "full" is representable.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ifetch_stage_if.sv
// Fetch-stage bundle: imem req/ack port, redirect input and the valid/ready instruction output.
interface ifetch_stage_if
  import ifetch_stage_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) ();

  logic               fetch_en;
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               redirect;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               ir_valid;
  logic               ir_ready;
  logic [INSTR_W-1:0] ir_instr;
  logic [ADDR_W-1:0]  ir_pc;

  modport master (
    input  fetch_en, imem_ack, imem_rdata, redirect, redirect_pc, ir_ready,
    output imem_req, imem_addr, ir_valid, ir_instr, ir_pc
  );

  modport slave (
    output fetch_en, imem_ack, imem_rdata, redirect, redirect_pc, ir_ready,
    input  imem_req, imem_addr, ir_valid, ir_instr, ir_pc
  );

endinterface

// File: rtl/ifetch_stage_fifo.sv
// Prefetch FIFO: registered push, head visible the cycle after push, flush clears in one cycle.
// When empty the output holds the last head shown rather than exposing stale storage.
module ifetch_stage_fifo
  import ifetch_stage_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter int WIDTH = ADDR_W_DEF + INSTR_W_DEF
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_dat_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [WIDTH-1:0] hold_q;
  logic [WIDTH-1:0] head;

  assign head    = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = empty_o ? hold_q : head;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      hold_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (!empty_o) begin
        hold_q <= head;
      end
      if (flush_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push_i) begin
          mem_q[wr_ptr_q] <= push_dat_i;
          wr_ptr_q        <= wr_ptr_q + 1'b1;
        end
        if (pop_i) begin
          rd_ptr_q <= rd_ptr_q + 1'b1;
        end
        unique case ({push_i, pop_i})
          2'b10:   count_q <= count_q + CNT_W'(1);
          2'b01:   count_q <= count_q - CNT_W'(1);
          default: count_q <= count_q;
        endcase
      end
    end
  end

endmodule

// File: rtl/ifetch_stage.sv
// Instruction fetch: owns the PC, one outstanding imem request, words buffered in a prefetch FIFO.
// Ack in cycle N shows on ir_* in N+1; no request is issued while the FIFO is full.
module ifetch_stage
  import ifetch_stage_pkg::*;
#(
  parameter int                ADDR_W     = ADDR_W_DEF,
  parameter int                INSTR_W    = INSTR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int                FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic          clk,
  input  logic          n_rst,
  ifetch_stage_if.master bus
);

  localparam int CNT_W = cnt_width(FIFO_DEPTH);
  localparam int ENT_W = ADDR_W + INSTR_W;

  fs_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic              push;
  logic              pop;
  logic              flush;
  logic              room;
  logic [CNT_W-1:0]  count;
  logic              empty;
  logic [ENT_W-1:0]  dout;

  // Room is judged on the current count only; the single outstanding request
  // therefore always has its slot reserved when the ack arrives.
  assign room = (count < CNT_W'(FIFO_DEPTH));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= FS_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FS_IDLE: begin
        if (!bus.redirect && bus.fetch_en && room) begin
          state_d = FS_REQ;
        end
      end
      FS_REQ: begin
        if (bus.imem_ack) begin
          state_d = FS_IDLE;
        end else if (bus.redirect) begin
          state_d = FS_DISCARD;
        end
      end
      FS_DISCARD: begin
        if (bus.imem_ack) begin
          state_d = FS_IDLE;
        end
      end
      default: state_d = FS_IDLE;
    endcase
  end

  always_comb begin
    flush  = bus.redirect;
    pop    = bus.ir_valid && bus.ir_ready;
    push   = (state_q == FS_REQ) && bus.imem_ack && !bus.redirect;
    req_d  = (state_d != FS_IDLE);
    addr_d = addr_q;
    pc_d   = pc_q;
    if ((state_q == FS_IDLE) && (state_d == FS_REQ)) begin
      addr_d = pc_q;
    end
    if (bus.redirect) begin
      pc_d = bus.redirect_pc;
    end else if (push) begin
      pc_d = pc_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pc_q   <= RESET_PC;
      req_q  <= 1'b0;
      addr_q <= RESET_PC;
    end else begin
      pc_q   <= pc_d;
      req_q  <= req_d;
      addr_q <= addr_d;
    end
  end

  ifetch_stage_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk        (clk),
    .n_rst      (n_rst),
    .push_i     (push),
    .push_dat_i ({addr_q, bus.imem_rdata}),
    .pop_i      (pop),
    .flush_i    (flush),
    .dout_o     (dout),
    .count_o    (count),
    .empty_o    (empty)
  );

  assign bus.imem_req          = req_q;
  assign bus.imem_addr         = addr_q;
  assign bus.ir_valid          = !empty;
  assign {bus.ir_pc, bus.ir_instr} = dout;

  a_addr_stable: assert property (@(posedge clk) disable iff (!n_rst)
    (bus.imem_req && !bus.imem_ack) |=> (bus.imem_req && $stable(bus.imem_addr)));

  a_push_room: assert property (@(posedge clk) disable iff (!n_rst)
    push |-> room);

endmodule

// File: tb/tb_ifetch_stage.sv
// Randomised bench for ifetch_stage with a queue-based reference model and directed scenarios.
module tb_ifetch_stage;
  import ifetch_stage_pkg::*;

  localparam int AW    = 8;
  localparam int IW    = 16;
  localparam int DEPTH = 2;

  logic clk   = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  ifetch_stage_if #(.ADDR_W(AW), .INSTR_W(IW)) bus ();

  ifetch_stage #(
    .ADDR_W(AW), .INSTR_W(IW), .RESET_PC(8'h00), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: a queue of buffered {pc,instr} plus the outstanding-request bookkeeping.
  logic [AW-1:0]    m_pc   = 8'h00;
  logic [AW-1:0]    m_addr = 8'h00;
  bit               m_busy = 1'b0;
  bit               m_drop = 1'b0;
  logic [AW+IW-1:0] mq[$];
  logic [AW+IW-1:0] m_last = '0;
  int               m_sz;

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      m_pc = 8'h00; m_addr = 8'h00; m_busy = 1'b0; m_drop = 1'b0;
      mq.delete(); m_last = '0;
    end else begin
      m_sz = mq.size();
      if (m_sz > 0 && bus.ir_ready) void'(mq.pop_front());
      if (bus.redirect) begin
        mq.delete();
        m_pc = bus.redirect_pc;
        if (m_busy) begin
          if (bus.imem_ack) begin m_busy = 1'b0; m_drop = 1'b0; end
          else m_drop = 1'b1;
        end
      end else if (m_busy) begin
        if (bus.imem_ack) begin
          if (!m_drop) begin
            mq.push_back({m_addr, bus.imem_rdata});
            m_pc = m_addr + 8'd1;
          end
          m_busy = 1'b0;
          m_drop = 1'b0;
        end
      end else if (bus.fetch_en && m_sz < DEPTH) begin
        m_busy = 1'b1;
        m_addr = m_pc;
      end
      if (mq.size() > 0) m_last = mq[0];
    end
  end

  always @(negedge clk) begin
    logic [AW+IW-1:0] head;
    head = (mq.size() > 0) ? mq[0] : m_last;
    chk("imem_req",  bus.imem_req,  m_busy);
    chk("imem_addr", bus.imem_addr, m_addr);
    chk("ir_valid",  bus.ir_valid,  mq.size() > 0);
    chk("ir_pc",     bus.ir_pc,     head[AW+IW-1:IW]);
    chk("ir_instr",  bus.ir_instr,  head[IW-1:0]);
  end

  logic [AW-1:0] pop_log[$];
  logic [AW-1:0] req_log[$];

  always @(posedge clk) begin
    if (n_rst) begin
      if (bus.ir_valid && bus.ir_ready) pop_log.push_back(bus.ir_pc);
      if (bus.imem_req && bus.imem_ack) req_log.push_back(bus.imem_addr);
    end
  end

  function automatic logic [31:0] qat(input logic [AW-1:0] q[$], input int i);
    if (i < q.size()) return {24'h0, q[i]};
    return 32'hDEAD_BEEF;
  endfunction

  bit mem_auto  = 1'b0;
  int max_delay = 0;
  int ack_wait  = 0;

  task automatic cyc();
    @(negedge clk);
    #1;
    if (mem_auto) begin
      if (bus.imem_req && n_rst) begin
        if (ack_wait <= 0) begin
          bus.imem_ack   = 1'b1;
          bus.imem_rdata = IW'($urandom);
          ack_wait       = $urandom_range(0, max_delay);
        end else begin
          bus.imem_ack = 1'b0;
          ack_wait--;
        end
      end else begin
        bus.imem_ack = 1'b0;
      end
    end
  endtask

  task automatic wait_req(input string nm);
    int n = 0;
    while (!bus.imem_req && n < 20) begin cyc(); n++; end
    if (!bus.imem_req) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: imem_req never rose, got 0, expected 1", nm);
    end
  endtask

  // Reset, then use a redirect in IDLE to pick the first fetch address.
  task automatic do_reset(input logic [AW-1:0] start);
    n_rst = 1'b0;
    bus.imem_ack = 1'b0;
    bus.redirect = 1'b1;
    bus.redirect_pc = start;
    ack_wait = 0;
    cyc();
    n_rst = 1'b1;
    cyc();
    bus.redirect = 1'b0;
    pop_log.delete();
    req_log.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int found5;
    bus.fetch_en = 1'b0; bus.imem_ack = 1'b0; bus.imem_rdata = '0;
    bus.redirect = 1'b0; bus.redirect_pc = '0; bus.ir_ready = 1'b0;

    repeat (2) cyc();
    chk("rst_req",   bus.imem_req,  0);
    chk("rst_addr",  bus.imem_addr, 0);
    chk("rst_valid", bus.ir_valid,  0);
    chk("rst_pc",    bus.ir_pc,     0);
    chk("rst_instr", bus.ir_instr,  0);

    // Fetch from reset, single-cycle ack, consumer stalled.
    n_rst = 1'b1; bus.fetch_en = 1'b1; mem_auto = 1'b1; max_delay = 0; ack_wait = 0;
    wait_req("t1_req");
    chk("t1_addr0", bus.imem_addr, 0);
    cyc();
    chk("t1_valid", bus.ir_valid, 1);
    chk("t1_pc0",   bus.ir_pc,    0);

    repeat (10) cyc();
    chk("t2_req_idle",  bus.imem_req,   0);
    chk("t2_nreq",      req_log.size(), 2);
    chk("t2_valid",     bus.ir_valid,   1);
    chk("t2_head",      bus.ir_pc,      0);
    bus.ir_ready = 1'b1;
    repeat (8) cyc();
    chk("t2_pop0", qat(pop_log, 0), 0);
    chk("t2_pop1", qat(pop_log, 1), 1);
    chk("t2_req1", qat(req_log, 1), 1);
    chk("t2_req2", qat(req_log, 2), 2);

    // Redirect while a request is in flight; its word must vanish.
    mem_auto = 1'b0; bus.fetch_en = 1'b1; bus.ir_ready = 1'b1;
    do_reset(8'h05);
    wait_req("t3_req5");
    chk("t3_addr5", bus.imem_addr, 8'h05);
    bus.redirect = 1'b1; bus.redirect_pc = 8'h40;
    cyc();
    bus.redirect = 1'b0;
    cyc();
    cyc();
    chk("t3_hold_req",  bus.imem_req,  1);
    chk("t3_hold_addr", bus.imem_addr, 8'h05);
    bus.imem_ack = 1'b1; bus.imem_rdata = 16'hDEAD;
    cyc();
    bus.imem_ack = 1'b0;
    wait_req("t3_req40");
    chk("t3_addr40", bus.imem_addr, 8'h40);
    bus.imem_ack = 1'b1; bus.imem_rdata = 16'h1234;
    cyc();
    bus.imem_ack = 1'b0;
    chk("t3_valid", bus.ir_valid, 1);
    chk("t3_pc",    bus.ir_pc,    8'h40);
    chk("t3_instr", bus.ir_instr, 16'h1234);
    cyc();
    found5 = 0;
    foreach (pop_log[i]) if (pop_log[i] == 8'h05) found5++;
    chk("t3_no05", found5, 0);

    // Redirect, ack and pop all in one cycle.
    bus.ir_ready = 1'b0;
    do_reset(8'h10);
    wait_req("t4_req10");
    bus.imem_ack = 1'b1; bus.imem_rdata = 16'hAAAA;
    cyc();
    bus.imem_ack = 1'b0;
    wait_req("t4_req11");
    chk("t4_addr11", bus.imem_addr, 8'h11);
    chk("t4_head",   bus.ir_pc,     8'h10);
    pop_log.delete();
    bus.imem_ack = 1'b1; bus.imem_rdata = 16'hBBBB;
    bus.ir_ready = 1'b1; bus.redirect = 1'b1; bus.redirect_pc = 8'h80;
    cyc();
    bus.imem_ack = 1'b0; bus.ir_ready = 1'b0; bus.redirect = 1'b0;
    chk("t4_empty",   bus.ir_valid,   0);
    chk("t4_req",     bus.imem_req,   0);
    chk("t4_npop",    pop_log.size(), 1);
    chk("t4_popped",  qat(pop_log, 0), 8'h10);
    chk("t4_hold_pc", bus.ir_pc,      8'h10);
    wait_req("t4_req80");
    chk("t4_addr80", bus.imem_addr, 8'h80);

    // PC wrap.
    mem_auto = 1'b1; max_delay = 0; bus.ir_ready = 1'b1;
    do_reset(8'hFF);
    repeat (8) cyc();
    chk("t5_reqFF", qat(req_log, 0), 8'hFF);
    chk("t5_req00", qat(req_log, 1), 8'h00);
    chk("t5_popFF", qat(pop_log, 0), 8'hFF);
    chk("t5_pop00", qat(pop_log, 1), 8'h00);

    // Asynchronous reset while a request is outstanding and the FIFO holds a word.
    mem_auto = 1'b0; bus.ir_ready = 1'b0;
    do_reset(8'h20);
    wait_req("t6_req20");
    bus.imem_ack = 1'b1; bus.imem_rdata = 16'h5555;
    cyc();
    bus.imem_ack = 1'b0;
    wait_req("t6_req21");
    chk("t6_pre_valid", bus.ir_valid, 1);
    n_rst = 1'b0;
    #1;
    chk("t6_req",   bus.imem_req,  0);
    chk("t6_addr",  bus.imem_addr, 0);
    chk("t6_valid", bus.ir_valid,  0);
    chk("t6_pc",    bus.ir_pc,     0);
    chk("t6_instr", bus.ir_instr,  0);
    cyc();

    // Random traffic against the model.
    mem_auto = 1'b1; max_delay = 3;
    do_reset(8'h00);
    for (int i = 0; i < 3000; i++) begin
      cyc();
      if (!n_rst) n_rst = 1'b1;
      else if ($urandom_range(0, 499) == 0) n_rst = 1'b0;
      bus.fetch_en = ($urandom_range(0, 9) != 0);
      bus.ir_ready = ($urandom_range(0, 2) != 0);
      bus.redirect = ($urandom_range(0, 19) == 0);
      bus.redirect_pc = ($urandom_range(0, 3) == 0) ? 8'hFE : AW'($urandom);
    end
    bus.redirect = 1'b0;
    repeat (4) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
